regfile_wb_arbiter: RTL and testbench

//  Shares the single regfile write port (wena/Rdc/datain) among three writeback sources: 0=ALU, 1=LSU, 2=MDU.

---
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the three sources (0=ALU, 1=LSU, 2=MDU).
// Sources drive valid/addr/data; the arbiter returns a one-hot ready.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic [2:0]      wb_valid;
  logic [3*AW-1:0] wb_addr;
  logic [3*DW-1:0] wb_data;
  logic [2:0]      wb_ready;

  modport master (
    output wb_valid,
    output wb_addr,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_addr,
    input  wb_data,
    output wb_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among ALU/LSU/MDU writebacks,
// with a registered write stage and a per-register busy scoreboard for RAW interlock.
module regfile_wb_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   wb,
  output logic                  rf_wena,
  output logic [AW-1:0]         rf_rdc,
  output logic [DW-1:0]         rf_datain,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  input  logic                  flush,
  input  logic [AW-1:0]         q_rs,
  input  logic [AW-1:0]         q_rt,
  output logic                  rs_busy,
  output logic                  rt_busy
);

  localparam int unsigned NReg = 1 << AW;

  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      grant;
  logic [1:0]      gidx;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NReg-1:0] busy_q, busy_d;

  // Priority scan starting at rr_ptr_q, wrapping mod 3.
  always_comb begin
    grant = '0;
    case (rr_ptr_q)
      2'd1: begin
        if (wb.wb_valid[1])      grant = 3'b010;
        else if (wb.wb_valid[2]) grant = 3'b100;
        else if (wb.wb_valid[0]) grant = 3'b001;
      end
      2'd2: begin
        if (wb.wb_valid[2])      grant = 3'b100;
        else if (wb.wb_valid[0]) grant = 3'b001;
        else if (wb.wb_valid[1]) grant = 3'b010;
      end
      default: begin
        if (wb.wb_valid[0])      grant = 3'b001;
        else if (wb.wb_valid[1]) grant = 3'b010;
        else if (wb.wb_valid[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    gidx = 2'd0;
    if (grant[1]) gidx = 2'd1;
    if (grant[2]) gidx = 2'd2;
  end

  assign xfer     = |grant;
  assign rr_ptr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;

  always_comb begin
    sel_addr = wb.wb_addr[0 +: AW];
    sel_data = wb.wb_data[0 +: DW];
    case (gidx)
      2'd1: begin
        sel_addr = wb.wb_addr[AW +: AW];
        sel_data = wb.wb_data[DW +: DW];
      end
      2'd2: begin
        sel_addr = wb.wb_addr[2*AW +: AW];
        sel_data = wb.wb_data[2*DW +: DW];
      end
      default: ;
    endcase
  end

  // Ready is suppressed while reset is held so no source sees a phantom transfer.
  assign wb.wb_ready = rst ? 3'b000 : grant;

  // Clear on the write edge, then set; set wins on a shared index, flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (rf_wena) busy_d[rf_rdc] = 1'b0;
      if (sb_set && (sb_addr != '0)) busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= 2'd0;
      rf_wena   <= 1'b0;
      rf_rdc    <= '0;
      rf_datain <= '0;
      busy_q    <= '0;
    end else begin
      busy_q <= busy_d;
      if (xfer) begin
        rr_ptr_q  <= rr_ptr_d;
        rf_rdc    <= sel_addr;
        rf_datain <= sel_data;
        rf_wena   <= (sel_addr != '0);
      end else begin
        rf_wena <= 1'b0;
      end
    end
  end

  assign rs_busy = busy_q[q_rs];
  assign rt_busy = busy_q[q_rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for arbitration/write stage,
// hand sequences for scoreboard, flush and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic       clk;
  logic       rst;
  logic       rf_wena;
  logic [4:0] rf_rdc;
  logic [31:0] rf_datain;
  logic       sb_set;
  logic [4:0] sb_addr;
  logic       flush;
  logic [4:0] q_rs;
  logic [4:0] q_rt;
  logic       rs_busy;
  logic       rt_busy;

  regfile_wb_arbiter_if #(.DW(32), .AW(5)) wb ();

  regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .rf_wena   (rf_wena),
    .rf_rdc    (rf_rdc),
    .rf_datain (rf_datain),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .flush     (flush),
    .q_rs      (q_rs),
    .q_rt      (q_rt),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  er;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [2:0] er, input logic ew,
                     input logic [4:0] ea, input logic [31:0] ed);
    vec_t t;
    t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.er = er; t.ew = ew; t.ea = ea; t.ed = ed;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2);
    wb.wb_valid = v;
    wb.wb_addr  = {a2, a1, a0};
    wb.wb_data  = {d2, d1, d0};
  endtask

  initial begin
    // Expected arbitration sequence starting from rr_ptr=0 after reset.
    add(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF);
    add(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF);
    add(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77, 3'b100, 1'b1, 5'd7, 32'h77);
    for (int r = 0; r < 2; r++) begin
      add(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11);
      add(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22);
      add(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33);
    end
    add(3'b010, 5'd1, 5'd0, 5'd3, 32'h11, 32'hFFFFFFFF, 32'h33, 3'b010, 1'b0, 5'd0, 32'hFFFFFFFF);
    add(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33);
    add(3'b101, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11);
    add(3'b101, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33);
    add(3'b110, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22);

    rst = 1'b1; sb_set = 1'b0; sb_addr = '0; flush = 1'b0; q_rs = 5'd8; q_rt = 5'd3;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    step();
    step();
    chk("rst ready", 32'(wb.wb_ready), 32'h0);
    chk("rst wena", 32'(rf_wena), 32'h0);
    chk("rst rs_busy", 32'(rs_busy), 32'h0);
    chk("rst rt_busy", 32'(rt_busy), 32'h0);
    chk("rst rdc", 32'(rf_rdc), 32'h0);
    chk("rst datain", rf_datain, 32'h0);
    rst = 1'b0;
    #1;
    chk("release grant", 32'(wb.wb_ready), 32'h1);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      #1;
      chk($sformatf("v%0d ready", i), 32'(wb.wb_ready), 32'(vecs[i].er));
      step();
      chk($sformatf("v%0d wena", i), 32'(rf_wena), 32'(vecs[i].ew));
      chk($sformatf("v%0d rdc", i), 32'(rf_rdc), 32'(vecs[i].ea));
      chk($sformatf("v%0d datain", i), rf_datain, vecs[i].ed);
    end
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    // Scoreboard: set r8, then MDU retires r8.
    q_rs = 5'd8; q_rt = 5'd8;
    sb_set = 1'b1; sb_addr = 5'd8;
    #1;
    chk("sb pre-set", 32'(rs_busy), 32'h0);
    step();
    sb_set = 1'b0;
    #1;
    chk("sb set rs", 32'(rs_busy), 32'h1);
    chk("sb set rt", 32'(rt_busy), 32'h1);
    drive(3'b100, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h88);
    #1;
    chk("mdu ready", 32'(wb.wb_ready), 32'h4);
    step();
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("mdu wena", 32'(rf_wena), 32'h1);
    chk("mdu rdc", 32'(rf_rdc), 32'd8);
    chk("busy during write", 32'(rs_busy), 32'h1);
    step();
    chk("mdu wena drop", 32'(rf_wena), 32'h0);
    chk("busy after write", 32'(rs_busy), 32'h0);

    // Same-edge clear and set of r8: set wins.
    sb_set = 1'b1; sb_addr = 5'd8;
    step();
    sb_set = 1'b0;
    drive(3'b100, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h99);
    step();
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    sb_set = 1'b1; sb_addr = 5'd8;
    chk("clr+set wena", 32'(rf_wena), 32'h1);
    step();
    sb_set = 1'b0;
    #1;
    chk("clr+set busy", 32'(rs_busy), 32'h1);

    // r0 is never busy.
    sb_set = 1'b1; sb_addr = 5'd0;
    step();
    sb_set = 1'b0; q_rs = 5'd0;
    #1;
    chk("r0 busy", 32'(rs_busy), 32'h0);

    // Flush clears r3/r9/r8, overrides sb_set, keeps the write going.
    sb_set = 1'b1; sb_addr = 5'd3;
    step();
    sb_addr = 5'd9;
    step();
    sb_set = 1'b0; q_rs = 5'd3; q_rt = 5'd9;
    #1;
    chk("r3 busy", 32'(rs_busy), 32'h1);
    chk("r9 busy", 32'(rt_busy), 32'h1);
    flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd3;
    drive(3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 32'h0, 32'h0);
    #1;
    chk("flush ready", 32'(wb.wb_ready), 32'h1);
    step();
    flush = 1'b0; sb_set = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("flush r3", 32'(rs_busy), 32'h0);
    chk("flush r9", 32'(rt_busy), 32'h0);
    chk("flush wena", 32'(rf_wena), 32'h1);
    chk("flush rdc", 32'(rf_rdc), 32'd4);
    q_rs = 5'd8;
    #1;
    chk("flush r8", 32'(rs_busy), 32'h0);

    // Asynchronous reset aborts a registered write.
    step();
    drive(3'b001, 5'd6, 5'd0, 5'd0, 32'h66, 32'h0, 32'h0);
    step();
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    chk("pre-abort wena", 32'(rf_wena), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort wena", 32'(rf_wena), 32'h0);
    chk("abort rdc", 32'(rf_rdc), 32'h0);
    chk("abort datain", rf_datain, 32'h0);
    chk("abort ready", 32'(wb.wb_ready), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("post-abort grant", 32'(wb.wb_ready), 32'h1);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
